arbitro_ram: RTL and testbench
==============================

# arbitro_ram

Read-only arbiter and access sequencer for the shared external 16-bit PSRAM. Two requesters share the RAM: the audio sample fetcher (one word per LRCLK period, feeding the sound serializer) and the note-pattern fetcher (feeding the falling-block lanes). The block grants one requester at a time, drives the RAM address and control strobes through a fixed wait-state read cycle, captures the data word, and returns it with a one-cycle acknowledge.

## Interface
Parameters:
- ADDR_W, 26, RAM address width
- DATA_W, 16, RAM data width
- WAIT_CYCLES, 4, clocks with `ram_oe_n` low before capture (4 × 20 ns ≥ 70 ns access time); legal range 1..15
- STARVE_MAX, 3, consecutive audio grants tolerated while a notes request is pending

Ports:
- clk, in, 1: 50 MHz system clock
- reset, in, 1: synchronous, active-high
- audio_req, in, 1: audio read request; held high until `audio_ack`
- audio_addr, in, ADDR_W: audio word address; stable while `audio_req` is high
- audio_ack, out, 1: one-cycle pulse; `audio_data` is valid in the same cycle
- audio_data, out, DATA_W: last word read for audio; held until the next audio ack
- notas_req, in, 1: notes read request, same rules as `audio_req`
- notas_addr, in, ADDR_W: notes word address
- notas_ack, out, 1: one-cycle pulse
- notas_data, out, DATA_W: last word read for notes; held until the next notes ack
- ram_addr, out, ADDR_W: RAM address bus
- ram_data_in, in, DATA_W: RAM data bus
- ram_ce_n, out, 1: chip enable, active-low
- ram_oe_n, out, 1: output enable, active-low
- ram_we_n, out, 1: write enable; constant 1 (the block only reads)
- busy, out, 1: high in every state other than IDLE

## Operation
- FSM states: IDLE → SETUP → WAIT → CAPTURE → RECOVER → IDLE.
- IDLE:
  - Samples both requests.
  - Grant rule: audio wins, except when `notas_req` is high and the starvation counter equals STARVE_MAX; then notes wins.
  - On a grant, registers the grant owner and the owner's address, then goes to SETUP.
  - With no request pending, stays in IDLE.
- SETUP: `ram_addr` = latched address, `ram_ce_n`=0, `ram_oe_n`=1.
- WAIT:
  - `ram_oe_n`=0, wait counter runs 0..WAIT_CYCLES-1.
  - Moves to CAPTURE when the counter reaches WAIT_CYCLES-1.
- CAPTURE: `ram_oe_n`=0; registers `ram_data_in` into the owner's data register.
- RECOVER:
  - `ram_ce_n`=1, `ram_oe_n`=1 (bus turnaround).
  - Owner's ack is high for this cycle only, with the new data.
- Starvation counter (2 bits):
  - Increments on each audio grant made while `notas_req` is high.
  - Clears on a notes grant, and in any IDLE cycle where `notas_req` is low.
  - Saturates at STARVE_MAX.
- A request dropped before its grant is withdrawn; no access occurs.
- A request dropped after its grant does not stop the access; it completes and the ack still pulses.
- The latched address is not affected if the requester changes its address mid-access.
- `ram_addr` holds its last value between accesses.

## Timing
- Reset values:
  - state IDLE
  - `ram_ce_n`, `ram_oe_n`, `ram_we_n` = 1
  - `ram_addr`, `audio_data`, `notas_data` = 0
  - both acks 0, `busy` 0, starvation counter 0
- Reset mid-access aborts immediately: strobes go high on the next edge and no ack is issued.
- Latency: request sampled in IDLE at cycle 0 → ack in cycle WAIT_CYCLES+3 (cycle 7 by default). Access period is WAIT_CYCLES+4 cycles.
- Back-to-back requests: the next IDLE is cycle WAIT_CYCLES+4. A requester that registers its ack drops `req` on that same edge, so it is never granted twice for one request.
- Simultaneous requests in IDLE: the grant rule above decides; the loser keeps `req` high and is served in the following access period.
- Audio worst case: one notes access (8 cycles) plus its own (8 cycles) = 16 cycles, far below one LRCLK period.

## Structure
- Shared package `drum_pkg`: FSM state encoding (3 bits), default WAIT_CYCLES, and the RAM ADDR_W/DATA_W constants, also used by the audio address walker and the note fetcher.
- No sub-module: the wait counter and the starvation counter are small, so the FSM and both counters stay inline.
- Integration: the top level maps `ram_ce_n`/`ram_oe_n`/`ram_we_n` into the existing 8-bit RAM control bundle.

## Test plan
- Reset, then a single `audio_req` with addr 0x0000123 and RAM model returning 0xBEEF: `ram_ce_n` low in cycles 1–6, `ram_oe_n` low in cycles 2–6, `audio_ack` in cycle 7 with `audio_data`=0xBEEF, `notas_ack` never asserts.
- Both requests high in the same IDLE cycle: audio served first (ack in cycle 7), notes ack in cycle 15, each with its own address on `ram_addr`.
- `audio_req` held high continuously and `notas_req` high: audio granted 3 times, the 4th grant goes to notes, after which the counter is 0.
- `notas_req` pulsed for 1 cycle while an audio access is in progress and dropped before IDLE: no notes access, `ram_addr` never shows `notas_addr`.
- `reset` asserted in the WAIT state: next cycle `ram_ce_n`=`ram_oe_n`=1, `busy`=0, no ack, data registers = 0.
- Sweep WAIT_CYCLES over 1, 4 and 15: ack latency equals WAIT_CYCLES+3 in every case, and `ram_we_n` stays 1 throughout.

Source files
------------

// File: rtl/drum_pkg.sv
// drum_pkg: shared PSRAM geometry, access timing defaults and arbiter types
package drum_pkg;
  localparam int RAM_ADDR_W = 26;
  localparam int RAM_DATA_W = 16;
  localparam int WAIT_CYCLES_DEF = 4;
  localparam int STARVE_MAX_DEF = 3;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WAIT, S_CAPTURE, S_RECOVER} state_t;
  typedef enum logic {OWN_AUDIO, OWN_NOTAS} owner_t;
endpackage

// File: rtl/arbitro_ram_if.sv
// arbitro_ram_if: requester handshakes and PSRAM read bus shared by the arbiter
// audio_*/notas_*: req + addr from requesters, ack + data back
// ram_*: address, data-in and active-low strobes towards the PSRAM
// busy: arbiter is running an access
// slave: arbiter side; master: requester/RAM environment side
interface arbitro_ram_if
  import drum_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
);
  logic audio_req;
  logic [ADDR_W-1:0] audio_addr;
  logic audio_ack;
  logic [DATA_W-1:0] audio_data;
  logic notas_req;
  logic [ADDR_W-1:0] notas_addr;
  logic notas_ack;
  logic [DATA_W-1:0] notas_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_in;
  logic ram_ce_n;
  logic ram_oe_n;
  logic ram_we_n;
  logic busy;
  modport slave (
    input audio_req, audio_addr, notas_req, notas_addr, ram_data_in,
    output audio_ack, audio_data, notas_ack, notas_data,
    output ram_addr, ram_ce_n, ram_oe_n, ram_we_n, busy
  );
  modport master (
    output audio_req, audio_addr, notas_req, notas_addr, ram_data_in,
    input audio_ack, audio_data, notas_ack, notas_data,
    input ram_addr, ram_ce_n, ram_oe_n, ram_we_n, busy
  );
endinterface

// File: rtl/arbitro_ram.sv
// arbitro_ram: read-only PSRAM arbiter between audio and note fetchers
// clk: 50 MHz system clock; reset: synchronous active-high
// bus (slave): requester req/addr in, ack/data out; PSRAM addr/strobes out,
//   data in; busy high whenever an access is in progress
module arbitro_ram
  import drum_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input logic clk,
  input logic reset,
  arbitro_ram_if.slave bus
);
  state_t state, state_nx;
  owner_t owner;
  logic [3:0] wcnt;
  logic [1:0] starve;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] audio_q, notas_q;
  logic grant_any, grant_notas;
  // notes only beats audio when audio is absent or has used up its streak
  always_comb begin
    grant_any = bus.audio_req || bus.notas_req;
    grant_notas = bus.notas_req && (!bus.audio_req || starve == 2'(STARVE_MAX));
    state_nx = state == S_IDLE ? (grant_any ? S_SETUP : S_IDLE) :
               state == S_SETUP ? S_WAIT :
               state == S_WAIT ? (wcnt == 4'(WAIT_CYCLES - 1) ? S_CAPTURE : S_WAIT) :
               state == S_CAPTURE ? S_RECOVER : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      owner <= OWN_AUDIO;
      wcnt <= '0;
      starve <= '0;
      addr_q <= '0;
      audio_q <= '0;
      notas_q <= '0;
    end else begin
      state <= state_nx;
      wcnt <= (state == S_WAIT) ? wcnt + 4'd1 : 4'd0;
      if (state == S_IDLE && grant_any) begin
        owner <= grant_notas ? OWN_NOTAS : OWN_AUDIO;
        addr_q <= grant_notas ? bus.notas_addr : bus.audio_addr;
      end
      // a pending notes request that loses in IDLE means audio was granted
      if (state == S_IDLE)
        starve <= (grant_notas || !bus.notas_req) ? 2'd0 :
                  (starve == 2'(STARVE_MAX)) ? starve : starve + 2'd1;
      if (state == S_CAPTURE && owner == OWN_AUDIO) audio_q <= bus.ram_data_in;
      if (state == S_CAPTURE && owner == OWN_NOTAS) notas_q <= bus.ram_data_in;
    end
  end
  assign bus.ram_addr = addr_q;
  assign bus.ram_ce_n = !(state == S_SETUP || state == S_WAIT || state == S_CAPTURE);
  assign bus.ram_oe_n = !(state == S_WAIT || state == S_CAPTURE);
  assign bus.ram_we_n = 1'b1;
  assign bus.busy = state != S_IDLE;
  assign bus.audio_ack = state == S_RECOVER && owner == OWN_AUDIO;
  assign bus.notas_ack = state == S_RECOVER && owner == OWN_NOTAS;
  assign bus.audio_data = audio_q;
  assign bus.notas_data = notas_q;
endmodule

// File: tb/tb_arbitro_ram.sv
// tb_arbitro_ram: randomized and directed checks of arbitro_ram against a timeline model
module tb_arbitro_ram;
  localparam int W = 4;
  localparam int SMAX = 3;
  logic clk, reset;
  logic a_req, n_req;
  logic [25:0] a_addr, n_addr;
  logic [1:0] sw_req, sw_ack, sw_we;
  logic [25:0] sw_addr [2];
  logic [15:0] sw_data [2];
  int cyc, idle_at, g_cyc, starve, n_chk, n_err;
  logic [25:0] g_addr;
  logic g_own, a_gr, n_gr, rnd, keep_a, keep_n;
  logic [15:0] exp_a, exp_n;

  function automatic logic [15:0] mem(input logic [25:0] a);
    return (a == 26'h123) ? 16'hBEEF : (a[15:0] ^ {a[25:16], 6'h2a} ^ 16'h5a5a);
  endfunction

  arbitro_ram_if #(.ADDR_W(26), .DATA_W(16)) bm ();
  arbitro_ram_if #(.ADDR_W(26), .DATA_W(16)) b1 ();
  arbitro_ram_if #(.ADDR_W(26), .DATA_W(16)) b15 ();
  arbitro_ram #(.WAIT_CYCLES(W), .STARVE_MAX(SMAX)) dut (.clk(clk), .reset(reset), .bus(bm));
  arbitro_ram #(.WAIT_CYCLES(1), .STARVE_MAX(SMAX)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  arbitro_ram #(.WAIT_CYCLES(15), .STARVE_MAX(SMAX)) dut15 (.clk(clk), .reset(reset), .bus(b15));

  assign bm.audio_req = a_req;
  assign bm.audio_addr = a_addr;
  assign bm.notas_req = n_req;
  assign bm.notas_addr = n_addr;
  assign bm.ram_data_in = mem(bm.ram_addr);
  assign b1.audio_req = sw_req[0];
  assign b1.audio_addr = sw_addr[0];
  assign b1.notas_req = 1'b0;
  assign b1.notas_addr = '0;
  assign b1.ram_data_in = mem(b1.ram_addr);
  assign b15.audio_req = sw_req[1];
  assign b15.audio_addr = sw_addr[1];
  assign b15.notas_req = 1'b0;
  assign b15.notas_addr = '0;
  assign b15.ram_data_in = mem(b15.ram_addr);
  assign sw_ack = {b15.audio_ack, b1.audio_ack};
  assign sw_we = {b15.ram_we_n, b1.ram_we_n};
  assign sw_data[0] = b1.audio_data;
  assign sw_data[1] = b15.audio_data;

  initial clk = 0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    idle_at = cyc;
    g_cyc = -100;
    g_addr = '0;
    g_own = 0;
    starve = 0;
    exp_a = '0;
    exp_n = '0;
    a_gr = 0;
    n_gr = 0;
  endtask

  // an access granted in cycle g drives the RAM in g+1..g+W+2 and acks in g+W+3
  task automatic model_decide();
    logic gn;
    if (cyc != idle_at) return;
    if (a_req || n_req) begin
      gn = n_req && (!a_req || starve == SMAX);
      starve = (gn || !n_req) ? 0 : (starve == SMAX ? SMAX : starve + 1);
      g_cyc = cyc;
      g_own = gn;
      g_addr = gn ? n_addr : a_addr;
      idle_at = cyc + W + 4;
      if (gn) n_gr = 1; else a_gr = 1;
    end else begin
      starve = 0;
      idle_at = cyc + 1;
    end
  endtask

  task automatic check_outputs();
    int ack;
    ack = g_cyc + W + 3;
    if (cyc == ack) begin
      if (g_own) exp_n = mem(g_addr); else exp_a = mem(g_addr);
    end
    chk("busy", 32'(bm.busy), 32'(cyc < idle_at));
    chk("ce_n", 32'(bm.ram_ce_n), 32'(!(cyc >= g_cyc + 1 && cyc <= g_cyc + W + 2)));
    chk("oe_n", 32'(bm.ram_oe_n), 32'(!(cyc >= g_cyc + 2 && cyc <= g_cyc + W + 2)));
    chk("we_n", 32'(bm.ram_we_n), 32'd1);
    chk("ram_addr", 32'(bm.ram_addr), 32'(g_addr));
    chk("audio_ack", 32'(bm.audio_ack), 32'(cyc == ack && !g_own));
    chk("notas_ack", 32'(bm.notas_ack), 32'(cyc == ack && g_own));
    chk("audio_data", 32'(bm.audio_data), 32'(exp_a));
    chk("notas_data", 32'(bm.notas_data), 32'(exp_n));
  endtask

  task automatic requesters();
    logic at_ack;
    at_ack = cyc == g_cyc + W + 3;
    if (a_gr) begin
      if (at_ack && !g_own) begin
        a_gr = 0;
        if (!keep_a) a_req = 0;
      end else if (rnd) begin
        if ($urandom_range(15) == 0) a_req = 0;
        if ($urandom_range(7) == 0) a_addr = 26'($urandom);
      end
    end else if (rnd) begin
      if (a_req) begin
        if ($urandom_range(15) == 0) a_req = 0;
      end else if ($urandom_range(2) == 0) begin
        a_req = 1;
        a_addr = 26'($urandom);
      end
    end
    if (n_gr) begin
      if (at_ack && g_own) begin
        n_gr = 0;
        if (!keep_n) n_req = 0;
      end else if (rnd) begin
        if ($urandom_range(15) == 0) n_req = 0;
        if ($urandom_range(7) == 0) n_addr = 26'($urandom);
      end
    end else if (rnd) begin
      if (n_req) begin
        if ($urandom_range(15) == 0) n_req = 0;
      end else if ($urandom_range(3) == 0) begin
        n_req = 1;
        n_addr = 26'($urandom);
      end
    end
  endtask

  task automatic tick();
    model_decide();
    @(negedge clk);
    cyc++;
    check_outputs();
    requesters();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && (bm.busy || a_req || n_req); i++) tick();
    chk("idle_timeout", 32'(bm.busy), 32'd0);
  endtask

  initial begin
    int t0, ta, tn, c1, c2, ns;
    logic seen;
    n_chk = 0; n_err = 0; cyc = 0;
    a_req = 0; n_req = 0; a_addr = '0; n_addr = '0;
    sw_req = '0; sw_addr[0] = '0; sw_addr[1] = '0;
    rnd = 0; keep_a = 0; keep_n = 0;
    reset = 1;
    repeat (3) begin @(negedge clk); cyc++; end
    reset = 0;
    model_reset();
    check_outputs();
    chk("rst_sw_we", 32'(sw_we), 32'h3);

    // single audio read of the BEEF word
    a_addr = 26'h123;
    a_req = 1;
    t0 = cyc;
    for (int i = 0; i < 30 && !bm.audio_ack; i++) tick();
    chk("t1_latency", 32'(cyc - t0), 32'(W + 3));
    chk("t1_data", 32'(bm.audio_data), 32'hBEEF);
    wait_idle();

    // simultaneous requests: audio first, notes one period later
    a_addr = 26'($urandom); n_addr = 26'($urandom);
    a_req = 1; n_req = 1;
    t0 = cyc; ta = -1; tn = -1;
    for (int i = 0; i < 40 && tn < 0; i++) begin
      tick();
      if (bm.audio_ack && ta < 0) ta = cyc;
      if (bm.notas_ack && tn < 0) tn = cyc;
    end
    chk("t2_audio_lat", 32'(ta - t0), 32'(W + 3));
    chk("t2_notas_lat", 32'(tn - t0), 32'(2 * W + 7));
    wait_idle();

    // both held high: three audio grants per notes grant
    keep_a = 1; keep_n = 1;
    a_req = 1; n_req = 1;
    c1 = 0; c2 = 0; ns = 0;
    for (int i = 0; i < 120 && ns < 2; i++) begin
      tick();
      if (bm.audio_ack) begin
        if (ns == 0) c1++; else c2++;
      end
      if (bm.notas_ack) begin
        ns++;
        if (ns == 2) begin keep_a = 0; keep_n = 0; a_req = 0; n_req = 0; end
      end
    end
    chk("t3_first_streak", 32'(c1), 32'(SMAX));
    chk("t3_second_streak", 32'(c2), 32'(SMAX));
    wait_idle();

    // notes pulse during an audio access is withdrawn before IDLE
    a_addr = 26'($urandom);
    n_addr = a_addr ^ 26'h1;
    a_req = 1;
    repeat (3) tick();
    n_req = 1;
    tick();
    n_req = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bm.ram_addr == n_addr || bm.notas_ack) seen = 1;
    end
    chk("t4_withdrawn", 32'(seen), 32'd0);
    wait_idle();

    // randomized traffic
    rnd = 1;
    repeat (3000) tick();
    rnd = 0;
    if (!a_gr) a_req = 0;
    if (!n_gr) n_req = 0;
    wait_idle();

    // reset during WAIT aborts the access
    a_addr = 26'($urandom);
    a_req = 1;
    repeat (2) tick();
    chk("t5_in_wait", 32'(bm.ram_oe_n), 32'd0);
    reset = 1;
    a_req = 0;
    @(negedge clk);
    cyc++;
    chk("t5_ce_n", 32'(bm.ram_ce_n), 32'd1);
    chk("t5_oe_n", 32'(bm.ram_oe_n), 32'd1);
    chk("t5_busy", 32'(bm.busy), 32'd0);
    chk("t5_acks", 32'({bm.audio_ack, bm.notas_ack}), 32'd0);
    chk("t5_data", 32'({bm.audio_data, bm.notas_data}), 32'd0);
    chk("t5_addr", 32'(bm.ram_addr), 32'd0);
    reset = 0;
    model_reset();
    repeat (12) tick();

    // latency sweep over WAIT_CYCLES 1 and 15
    for (int k = 0; k < 2; k++) begin
      sw_addr[k] = 26'($urandom);
      sw_req[k] = 1;
      t0 = cyc;
      for (int i = 0; i < 40 && !sw_ack[k]; i++) begin
        tick();
        chk("sweep_we_n", 32'(sw_we), 32'h3);
      end
      sw_req[k] = 0;
      chk("sweep_latency", 32'(cyc - t0), k == 0 ? 32'd4 : 32'd18);
      chk("sweep_data", 32'(sw_data[k]), 32'(mem(sw_addr[k])));
      repeat (3) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
